// File: rtl/kl_ebus_pkg.sv
// Shared EBUS diagnostic definitions: bus widths, sequencer states and
// default DS/strobe timing.
package kl_ebus_pkg;

  localparam int DS_W   = 7;
  localparam int EBUS_W = 36;
  localparam int CNT_W  = 4;

  localparam int SETUP_CYC_DEF  = 2;
  localparam int STROBE_CYC_DEF = 4;
  localparam int HOLD_CYC_DEF   = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_e;

  // States in which DS (and a front-end write driver) are presented on EBUS.
  function automatic logic ds_phase(seq_state_e s);
    return (s == ST_SETUP) || (s == ST_STROBE) || (s == ST_HOLD);
  endfunction

  function automatic logic [CNT_W-1:0] cnt_load(int cyc);
    return CNT_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/ebus_sample_mux.sv
// Combinational EBUS data merge: OR of every driving board's data plus
// none / more-than-one driver decode.
module ebus_sample_mux
  import kl_ebus_pkg::*;
#(
  parameter int NDRV = 24
) (
  input  logic [NDRV-1:0]               drv_driving_i,
  input  logic [NDRV-1:0][0:EBUS_W-1]   drv_data_i,
  output logic [0:EBUS_W-1]             merged_o,
  output logic                          none_o,
  output logic                          multi_o
);

  always_comb begin
    merged_o = '0;
    for (int i = 0; i < NDRV; i++) begin
      if (drv_driving_i[i]) begin
        merged_o = merged_o | drv_data_i[i];
      end
    end
  end

  assign none_o  = ~|drv_driving_i;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_o = |(drv_driving_i & (drv_driving_i - NDRV'(1)));

endmodule

// File: rtl/ebus_diag_seq.sv
// EBUS diagnostic cycle sequencer: DS setup, diag strobe, hold, then a
// one-cycle done pulse with the sampled read data and bus error flags.
module ebus_diag_seq
  import kl_ebus_pkg::*;
#(
  parameter int NDRV       = 24,
  parameter int SETUP_CYC  = SETUP_CYC_DEF,
  parameter int STROBE_CYC = STROBE_CYC_DEF,
  parameter int HOLD_CYC   = HOLD_CYC_DEF
) (
  input  logic                         clk,
  input  logic                         reset_l,
  input  logic                         req_h,
  input  logic                         write_h,
  input  logic [DS_W-1:0]              func,
  input  logic [0:EBUS_W-1]            wdata,
  input  logic [NDRV-1:0]              drv_driving,
  input  logic [NDRV-1:0][0:EBUS_W-1]  drv_data,
  output logic                         busy_h,
  output logic                         done_h,
  output logic [0:EBUS_W-1]            rdata,
  output logic                         err_contention_h,
  output logic                         err_nodrv_h,
  output logic [DS_W-1:0]              ds,
  output logic                         diag_strobe_h,
  output logic                         fe_driving_h,
  output logic [0:EBUS_W-1]            fe_data
);

  localparam logic [CNT_W-1:0] SETUP_LOAD  = cnt_load(SETUP_CYC);
  localparam logic [CNT_W-1:0] STROBE_LOAD = cnt_load(STROBE_CYC);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = cnt_load(HOLD_CYC);

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept, sample;

  logic [DS_W-1:0]    func_q, func_d;
  logic               write_q, write_d;
  logic [0:EBUS_W-1]  wdata_q, wdata_d;

  logic [DS_W-1:0]    ds_q, ds_d;
  logic               strobe_q, strobe_d;
  logic               fe_drv_q, fe_drv_d;
  logic [0:EBUS_W-1]  fe_data_q, fe_data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [0:EBUS_W-1]  rdata_q, rdata_d;
  logic               err_con_q, err_con_d;
  logic               err_nodrv_q, err_nodrv_d;

  logic [0:EBUS_W-1]  mux_data;
  logic               mux_none, mux_multi;

  ebus_sample_mux #(.NDRV(NDRV)) u_mux (
    .drv_driving_i (drv_driving),
    .drv_data_i    (drv_data),
    .merged_o      (mux_data),
    .none_o        (mux_none),
    .multi_o       (mux_multi)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    sample  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_h) begin
          state_d = ST_SETUP;
          cnt_d   = SETUP_LOAD;
          accept  = 1'b1;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = STROBE_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
          sample  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    func_d  = accept ? func    : func_q;
    write_d = accept ? write_h : write_q;
    wdata_d = accept ? wdata   : wdata_q;

    // Outputs are registered from the next state so EBUS lines never glitch.
    ds_d      = ds_phase(state_d) ? func_d : '0;
    strobe_d  = (state_d == ST_STROBE);
    fe_drv_d  = ds_phase(state_d) && write_d;
    fe_data_d = fe_drv_d ? wdata_d : '0;
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);

    rdata_d     = rdata_q;
    err_con_d   = err_con_q;
    err_nodrv_d = err_nodrv_q;
    if (accept) begin
      rdata_d     = '0;
      err_con_d   = 1'b0;
      err_nodrv_d = 1'b0;
    end else if (sample) begin
      if (write_q) begin
        // The front end owns the bus on a write; any board driving collides.
        rdata_d   = '0;
        err_con_d = ~mux_none;
      end else begin
        rdata_d     = mux_data;
        err_con_d   = mux_multi;
        err_nodrv_d = mux_none;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ds_q        <= '0;
      strobe_q    <= 1'b0;
      fe_drv_q    <= 1'b0;
      fe_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      err_con_q   <= 1'b0;
      err_nodrv_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ds_q        <= ds_d;
      strobe_q    <= strobe_d;
      fe_drv_q    <= fe_drv_d;
      fe_data_q   <= fe_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      err_con_q   <= err_con_d;
      err_nodrv_q <= err_nodrv_d;
    end
  end

  // Request latches are only observed after an accept, so they need no reset.
  always_ff @(posedge clk) begin
    func_q  <= func_d;
    write_q <= write_d;
    wdata_q <= wdata_d;
  end

  assign busy_h           = busy_q;
  assign done_h           = done_q;
  assign rdata            = rdata_q;
  assign err_contention_h = err_con_q;
  assign err_nodrv_h      = err_nodrv_q;
  assign ds               = ds_q;
  assign diag_strobe_h    = strobe_q;
  assign fe_driving_h     = fe_drv_q;
  assign fe_data          = fe_data_q;

endmodule

// File: tb/tb_ebus_diag_seq.sv
// Directed bench for ebus_diag_seq: scoreboard of expected diagnostic cycles,
// checked cycle by cycle against the default SETUP/STROBE/HOLD timing.
module tb_ebus_diag_seq;

  localparam int NDRV = 24;

  logic                    clk = 1'b0;
  logic                    reset_l = 1'b0;
  logic                    req_h = 1'b0;
  logic                    write_h = 1'b0;
  logic [6:0]              func = '0;
  logic [0:35]             wdata = '0;
  logic [NDRV-1:0]         drv_driving = '0;
  logic [NDRV-1:0][0:35]   drv_data = '0;

  logic                    busy_h, done_h, err_contention_h, err_nodrv_h;
  logic                    diag_strobe_h, fe_driving_h;
  logic [0:35]             rdata, fe_data;
  logic [6:0]              ds;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          t_acc;
    logic        wr;
    logic [6:0]  fn;
    logic [0:35] wd;
    logic [0:35] rd;
    logic        con;
    logic        nodrv;
  } exp_t;

  exp_t sb[$];

  ebus_diag_seq #(.NDRV(NDRV)) dut (
    .clk              (clk),
    .reset_l          (reset_l),
    .req_h            (req_h),
    .write_h          (write_h),
    .func             (func),
    .wdata            (wdata),
    .drv_driving      (drv_driving),
    .drv_data         (drv_data),
    .busy_h           (busy_h),
    .done_h           (done_h),
    .rdata            (rdata),
    .err_contention_h (err_contention_h),
    .err_nodrv_h      (err_nodrv_h),
    .ds               (ds),
    .diag_strobe_h    (diag_strobe_h),
    .fe_driving_h     (fe_driving_h),
    .fe_data          (fe_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc %0d got %0b exp %0b", tag, cyc, got, exp);
    end
  endtask

  task automatic chk7(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc %0d got %o exp %o", tag, cyc, got, exp);
    end
  endtask

  task automatic chk36(input string tag, input logic [0:35] got, input logic [0:35] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc %0d got %o exp %o", tag, cyc, got, exp);
    end
  endtask

  task automatic push_exp(input int t_acc, input logic wr, input logic [6:0] fn,
                          input logic [0:35] wd, input logic [0:35] rd,
                          input logic con, input logic nodrv);
    exp_t e;
    e.t_acc = t_acc;
    e.wr    = wr;
    e.fn    = fn;
    e.wd    = wd;
    e.rd    = rd;
    e.con   = con;
    e.nodrv = nodrv;
    sb.push_back(e);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of cycle 1.
  task automatic start(input logic wr, input logic [6:0] fn, input logic [0:35] wd,
                       input logic [0:35] rd, input logic con, input logic nodrv);
    push_exp(cyc + 1, wr, fn, wd, rd, con, nodrv);
    write_h = wr;
    func    = fn;
    wdata   = wd;
    req_h   = 1'b1;
    @(negedge clk);
    req_h = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL done_timeout cyc %0d got pending %0d exp pending 0", cyc, sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Per-cycle expectations relative to the accepting edge (cycle 1 follows it).
  always @(negedge clk) begin
    int   rel;
    logic on;
    if (reset_l) begin
      if (sb.size() == 0) begin
        chk1("idle_busy", busy_h, 1'b0);
        chk1("idle_done", done_h, 1'b0);
      end else begin
        rel = cyc - sb[0].t_acc + 1;
        if (rel < 1) begin
          chk1("pre_busy", busy_h, 1'b0);
        end else if (rel <= 8) begin
          on = (rel <= 7);
          chk1("busy", busy_h, 1'b1);
          chk1("strobe", diag_strobe_h, (rel >= 3) && (rel <= 6));
          chk7("ds", ds, on ? sb[0].fn : 7'o0);
          chk1("fe_driving", fe_driving_h, on && sb[0].wr);
          chk36("fe_data", fe_data, (on && sb[0].wr) ? sb[0].wd : 36'o0);
          chk1("done", done_h, rel == 8);
          if (rel == 8) begin
            chk36("rdata", rdata, sb[0].rd);
            chk1("err_contention", err_contention_h, sb[0].con);
            chk1("err_nodrv", err_nodrv_h, sb[0].nodrv);
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc %0d got no finish exp finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;

    repeat (3) @(negedge clk);
    chk1("rst_busy", busy_h, 1'b0);
    chk1("rst_done", done_h, 1'b0);
    chk1("rst_strobe", diag_strobe_h, 1'b0);
    chk7("rst_ds", ds, 7'o0);
    chk1("rst_fe_driving", fe_driving_h, 1'b0);
    chk36("rst_fe_data", fe_data, 36'o0);
    chk36("rst_rdata", rdata, 36'o0);
    chk1("rst_err_con", err_contention_h, 1'b0);
    chk1("rst_err_nodrv", err_nodrv_h, 1'b0);
    reset_l = 1'b1;
    @(negedge clk);

    // Single driver: board 5; board 6 carries data but is not driving.
    drv_data[5] = 36'o123456701234;
    drv_data[6] = 36'o555555555555;
    drv_driving = '0;
    drv_driving[5] = 1'b1;
    start(1'b0, 7'o15, 36'o0, 36'o123456701234, 1'b0, 1'b0);
    wait_idle();

    // No driver.
    drv_driving = '0;
    start(1'b0, 7'o22, 36'o0, 36'o0, 1'b0, 1'b1);
    wait_idle();
    chk1("sticky_nodrv", err_nodrv_h, 1'b1);

    // Two drivers: OR-merge and contention.
    drv_data[2] = 36'o700000000000;
    drv_data[9] = 36'o000000000007;
    drv_driving = '0;
    drv_driving[2] = 1'b1;
    drv_driving[9] = 1'b1;
    start(1'b0, 7'o03, 36'o0, 36'o700000000007, 1'b1, 1'b0);
    wait_idle();
    chk1("sticky_con", err_contention_h, 1'b1);
    chk36("sticky_rdata", rdata, 36'o700000000007);

    // Write with board 3 driving at sample.
    drv_data[3] = 36'o000111000111;
    drv_driving = '0;
    drv_driving[3] = 1'b1;
    start(1'b1, 7'o71, 36'o777777000000, 36'o0, 1'b1, 1'b0);
    wait_idle();

    // Clean write.
    drv_driving = '0;
    start(1'b1, 7'o02, 36'o000000777777, 36'o0, 1'b0, 1'b0);
    wait_idle();

    // Reset during STROBE aborts the cycle with no done.
    drv_driving = '0;
    drv_driving[5] = 1'b1;
    start(1'b0, 7'o44, 36'o0, 36'o123456701234, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 reset_l = 1'b0;
    #1;
    chk1("abort_strobe", diag_strobe_h, 1'b0);
    chk7("abort_ds", ds, 7'o0);
    chk1("abort_busy", busy_h, 1'b0);
    chk1("abort_done", done_h, 1'b0);
    chk36("abort_rdata", rdata, 36'o0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset_l = 1'b1;
    @(negedge clk);
    start(1'b0, 7'o15, 36'o0, 36'o123456701234, 1'b0, 1'b0);
    wait_idle();

    // req_h held high: accepts every 9 cycles, never from DONE.
    c0 = cyc;
    for (int k = 0; k < 3; k++) begin
      push_exp(c0 + 1 + 9 * k, 1'b0, 7'o60, 36'o0, 36'o123456701234, 1'b0, 1'b0);
    end
    write_h = 1'b0;
    func    = 7'o60;
    req_h   = 1'b1;
    for (int n = 0; n < 60 && cyc < c0 + 19; n++) @(negedge clk);
    req_h = 1'b0;
    wait_idle();
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ebus_diag_seq.md
EBUS_DIAG_SEQ -- requirements
Module: ebus_diag_seq

Interface
REQ-001 Parameter NDRV, default 24: number of board EBUS drivers observed.
REQ-002 Parameter SETUP_CYC, default 2: cycles DS is stable before strobe (range 1-15).
REQ-003 Parameter STROBE_CYC, default 4: cycles diag_strobe_h is asserted (range 1-15).
REQ-004 Parameter HOLD_CYC, default 1: cycles DS is held after strobe (range 1-15).
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset_l  in  1  asynchronous, active-low reset.
REQ-007 req_h  in  1  front-end request to start a diagnostic cycle.
REQ-008 write_h  in  1  1 = diagnostic write, 0 = diagnostic read; sampled with req_h.
REQ-009 func  in  7  diagnostic function code (EBUS DS00-06); sampled with req_h.
REQ-010 wdata  in  36  write data, bit 0 = MSB; sampled with req_h.
REQ-011 drv_driving  in  NDRV  per-board "driving EBUS data" flags.
REQ-012 drv_data  in  NDRV x 36  per-board EBUS data.
REQ-013 busy_h  out  1  sequencer not idle.
REQ-014 done_h  out  1  one-cycle completion pulse.
REQ-015 rdata  out  36  read result, valid from done_h until next accept.
REQ-016 err_contention_h  out  1  more than one source drove EBUS at sample.
REQ-017 err_nodrv_h  out  1  read sample found no driver.
REQ-018 ds  out  7  EBUS DS lines.
REQ-019 diag_strobe_h  out  1  EBUS diagnostic strobe.
REQ-020 fe_driving_h / fe_data  out  1 / 36  front-end EBUS driver record for the data mux.

Function
REQ-021 States: IDLE, SETUP, STROBE, HOLD, DONE; single down-counter (4 bits) times SETUP/STROBE/HOLD.
REQ-022 IDLE: req_h=1 at an edge accepts; latch func, write_h, wdata; clear both error flags; enter SETUP with counter = SETUP_CYC-1.
REQ-023 req_h in any state other than IDLE is ignored, not queued.
REQ-024 ds = latched func in SETUP, STROBE, HOLD; ds = 0 in IDLE and DONE.
REQ-025 SETUP lasts SETUP_CYC cycles, then STROBE with counter = STROBE_CYC-1.
REQ-026 diag_strobe_h = 1 exactly in STROBE (STROBE_CYC cycles), registered, glitch-free.
REQ-027 fe_driving_h = 1 and fe_data = latched wdata in SETUP, STROBE, HOLD of a write; otherwise fe_driving_h = 0, fe_data = 0.
REQ-028 Sample point: final STROBE cycle (counter = 0).
REQ-029 Read sample: exactly one drv_driving bit set -> rdata = that board's data; none -> rdata = 0, err_nodrv_h = 1; two or more -> rdata = bitwise OR of all driving boards' data, err_contention_h = 1.
REQ-030 Write sample: any drv_driving bit set -> err_contention_h = 1; rdata = 0.
REQ-031 HOLD lasts HOLD_CYC cycles, then DONE; DONE lasts one cycle with done_h = 1, then IDLE.
REQ-032 Latency: accept at edge T0 -> done_h high during cycle T0+SETUP_CYC+STROBE_CYC+HOLD_CYC+1 (defaults: cycle 8).
REQ-033 busy_h = 1 in SETUP, STROBE, HOLD, DONE.
REQ-034 Error flags and rdata sticky until next accept; req_h with done_h high is not accepted until IDLE.

Reset
REQ-035 reset_l low asynchronously forces IDLE, counter 0, all outputs 0 (ds, strobe, fe_driving_h, fe_data, rdata, flags, busy_h, done_h).
REQ-036 Reset mid-cycle aborts without done_h; first accept after reset_l rises behaves as from cold reset.

Structure
REQ-037 State enum, DS width (7), EBUS data width (36), default timing constants live in shared package kl_ebus_pkg.
REQ-038 One sub-module, ebus_sample_mux: combinational one-hot/zero/multi decode and OR-merge of drv_data.

Verification
REQ-039 Read, board 5 driving 36'o123456701234, defaults -> done_h at cycle 8, rdata = 36'o123456701234, no errors, strobe high cycles 3-6.
REQ-040 Read, no driver -> rdata = 0, err_nodrv_h = 1, err_contention_h = 0.
REQ-041 Read, boards 2 (36'o700000000000) and 9 (36'o000000000007) driving -> rdata = 36'o700000000007, err_contention_h = 1.
REQ-042 Write func 7'o71, wdata 36'o777777000000 -> ds = 7'o71 cycles 1-7, fe_driving_h cycles 1-7, board 3 driving at sample -> err_contention_h = 1.
REQ-043 reset_l low during STROBE -> strobe, ds, busy_h drop immediately; no done_h; next read completes normally.
REQ-044 req_h held high continuously -> back-to-back cycles, done_h every 9 cycles, DONE-cycle request not accepted.
